// File: rtl/sprite_mover.sv
// Bouncing sprite generator.
// Once per frame (on the vsync falling edge) the sprite moves STEP pixels
// diagonally and reflects off the active-area borders. For every pixel
// position presented on hcount/vcount the block reports, one cycle later,
// whether that pixel is covered by the sprite and which colour to blend.
module sprite_mover #(
    parameter int unsigned HRES   = 1024,        // active pixels per line
    parameter int unsigned VRES   = 768,         // active lines per frame
    parameter int unsigned WIDTH  = 64,          // sprite width in pixels
    parameter int unsigned HEIGHT = 64,          // sprite height in lines
    parameter int unsigned STEP   = 4,           // pixels moved per frame per axis
    parameter logic [23:0] COLOR  = 24'hFF_00_00 // sprite RGB
) (
    input  logic        clock,        // pixel clock
    input  logic        reset_n,      // asynchronous active-low reset
    input  logic [10:0] hcount,       // current pixel column
    input  logic [9:0]  vcount,       // current pixel line
    input  logic        vsync,        // active-low vertical sync
    input  logic        enable,       // motion enable, sampled on frame ticks only
    output logic [23:0] object_color, // COLOR inside the sprite, 0 outside
    output logic        object_hit,   // current pixel lies inside the sprite
    output logic [10:0] x_pos,        // sprite left edge
    output logic [9:0]  y_pos,        // sprite top edge
    output logic        bounce        // one-cycle pulse per direction reversal
);

    // Direction encoding: bit 1 set = moving left, bit 0 set = moving up.
    typedef enum logic [1:0] {
        RIGHT_DOWN = 2'b00,
        RIGHT_UP   = 2'b01,
        LEFT_DOWN  = 2'b10,
        LEFT_UP    = 2'b11
    } state_e;

    // Geometry constants sized to the widened intermediates (one bit wider
    // than the position) so x_pos+STEP and x_pos+WIDTH can never wrap.
    localparam logic [11:0] X_MAX  = 12'(HRES - WIDTH);
    localparam logic [11:0] X_STEP = 12'(STEP);
    localparam logic [11:0] X_SIZE = 12'(WIDTH);
    localparam logic [11:0] X_RES  = 12'(HRES);
    localparam logic [10:0] Y_MAX  = 11'(VRES - HEIGHT);
    localparam logic [10:0] Y_STEP = 11'(STEP);
    localparam logic [10:0] Y_SIZE = 11'(HEIGHT);
    localparam logic [10:0] Y_RES  = 11'(VRES);

    // Position-sized copies used when stepping back towards zero.
    localparam logic [10:0] X_STEP_P = 11'(STEP);
    localparam logic [9:0]  Y_STEP_P = 10'(STEP);
    localparam logic [10:0] X_MAX_P  = 11'(HRES - WIDTH);
    localparam logic [9:0]  Y_MAX_P  = 10'(VRES - HEIGHT);

    state_e      state_q, state_d;
    logic        vsync_q;
    logic [10:0] x_pos_q, x_pos_d;
    logic [9:0]  y_pos_q, y_pos_d;
    logic        bounce_q, bounce_d;
    logic        hit_q, hit_d;
    logic [23:0] color_q, color_d;

    logic        frame_tick;
    logic        move;
    logic        dir_left;
    logic        dir_up;
    logic        flip_x;
    logic        flip_y;
    logic [11:0] x_ext;
    logic [11:0] x_sum;
    logic [10:0] y_ext;
    logic [10:0] y_sum;
    logic [11:0] h_ext;
    logic [10:0] v_ext;
    logic        in_x;
    logic        in_y;

    // Delayed vsync for falling-edge detection; resets high so releasing
    // reset while vsync is idle-high cannot fake a frame tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q <= 1'b1;
        end else begin
            // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
            vsync_q <= vsync;
        end
    end

    assign frame_tick = vsync_q & ~vsync;
    assign move       = frame_tick & enable;

    // Decode the current travel direction from the FSM state.
    always_comb begin
        dir_left = (state_q == LEFT_DOWN) || (state_q == LEFT_UP);
        dir_up   = (state_q == RIGHT_UP)  || (state_q == LEFT_UP);
    end

    // Horizontal step with clamp-and-reflect at either border.
    always_comb begin
        // NOTE: defaults first so no path through the block infers a latch.
        x_pos_d = x_pos_q;
        flip_x  = 1'b0;
        x_ext   = {1'b0, x_pos_q};
        x_sum   = x_ext + X_STEP;
        if (move) begin
            if (!dir_left) begin
                if (x_sum >= X_MAX) begin
                    x_pos_d = X_MAX_P;
                    flip_x  = 1'b1;
                end else begin
                    x_pos_d = x_pos_q + X_STEP_P;
                end
            end else begin
                if (x_ext <= X_STEP) begin
                    x_pos_d = '0;
                    flip_x  = 1'b1;
                end else begin
                    x_pos_d = x_pos_q - X_STEP_P;
                end
            end
        end
    end

    // Vertical step, mirroring the horizontal rules on the UP/DOWN axis.
    always_comb begin
        y_pos_d = y_pos_q;
        flip_y  = 1'b0;
        y_ext   = {1'b0, y_pos_q};
        y_sum   = y_ext + Y_STEP;
        if (move) begin
            if (!dir_up) begin
                if (y_sum >= Y_MAX) begin
                    y_pos_d = Y_MAX_P;
                    flip_y  = 1'b1;
                end else begin
                    y_pos_d = y_pos_q + Y_STEP_P;
                end
            end else begin
                if (y_ext <= Y_STEP) begin
                    y_pos_d = '0;
                    flip_y  = 1'b1;
                end else begin
                    y_pos_d = y_pos_q - Y_STEP_P;
                end
            end
        end
    end

    // FSM next state: reflect whichever axes hit a border; pulse bounce once.
    always_comb begin
        state_d  = state_q;
        bounce_d = 1'b0;
        if (move) begin
            state_d  = state_e'({dir_left ^ flip_x, dir_up ^ flip_y});
            bounce_d = flip_x | flip_y;
        end
    end

    // FSM state, position and bounce registers; these only change on ticks,
    // which fall inside vsync, so the sprite never tears mid-frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RIGHT_DOWN;
            x_pos_q  <= '0;
            y_pos_q  <= '0;
            bounce_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_pos_q  <= x_pos_d;
            y_pos_q  <= y_pos_d;
            bounce_q <= bounce_d;
        end
    end

    // Pixel coverage test against the position current this cycle; pixels
    // outside the active area never hit.
    always_comb begin
        h_ext   = {1'b0, hcount};
        v_ext   = {1'b0, vcount};
        in_x    = (h_ext >= {1'b0, x_pos_q}) && (h_ext < ({1'b0, x_pos_q} + X_SIZE))
                  && (h_ext < X_RES);
        in_y    = (v_ext >= {1'b0, y_pos_q}) && (v_ext < ({1'b0, y_pos_q} + Y_SIZE))
                  && (v_ext < Y_RES);
        hit_d   = in_x & in_y;
        color_d = hit_d ? COLOR : 24'h0;
    end

    // Hit flag and colour registered together so they stay cycle-aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_q   <= 1'b0;
            color_q <= '0;
        end else begin
            hit_q   <= hit_d;
            color_q <= color_d;
        end
    end

    assign x_pos        = x_pos_q;
    assign y_pos        = y_pos_q;
    assign bounce       = bounce_q;
    assign object_hit   = hit_q;
    assign object_color = color_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: a default-size instance and a small
// 128x128 instance for the simultaneous corner reflection.
module tb_sprite_mover;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Default-parameter instance signals.
    logic        reset_n, vsync, enable;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [23:0] object_color;
    logic        object_hit, bounce;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;

    // Small instance signals.
    logic        reset_n_s, vsync_s, enable_s;
    logic [10:0] hcount_s;
    logic [9:0]  vcount_s;
    logic [23:0] object_color_s;
    logic        object_hit_s, bounce_s;
    logic [10:0] x_pos_s;
    logic [9:0]  y_pos_s;

    sprite_mover dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .vsync(vsync), .enable(enable), .object_color(object_color),
        .object_hit(object_hit), .x_pos(x_pos), .y_pos(y_pos), .bounce(bounce)
    );

    sprite_mover #(.HRES(128), .VRES(128), .WIDTH(32), .HEIGHT(32), .STEP(4)) dut_s (
        .clock(clock), .reset_n(reset_n_s), .hcount(hcount_s), .vcount(vcount_s),
        .vsync(vsync_s), .enable(enable_s), .object_color(object_color_s),
        .object_hit(object_hit_s), .x_pos(x_pos_s), .y_pos(y_pos_s), .bounce(bounce_s)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Hit/colour vectors: group 0 with sprite at (0,0), group 1 at (960,448).
    typedef struct {
        int          grp;
        logic [10:0] h;
        logic [9:0]  v;
        logic        hit;
        logic [23:0] color;
    } hit_vec_t;

    localparam int NV = 12;
    hit_vec_t vecs [NV];

    task automatic apply_group(input int g);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].grp == g) begin
                hcount = vecs[i].h;
                vcount = vecs[i].v;
                step();
                check($sformatf("hit_vec%0d", i), 32'(object_hit), 32'(vecs[i].hit));
                check($sformatf("color_vec%0d", i), 32'(object_color), 32'(vecs[i].color));
            end
        end
    endtask

    // Reference motion model for the default instance (1024x768, 64x64, step 4).
    int ex, ey;
    bit eleft, eup, ebounce;

    task automatic model_tick();
        ebounce = 1'b0;
        if (!eleft) begin
            if (ex + 4 >= 960) begin ex = 960; eleft = 1'b1; ebounce = 1'b1; end
            else ex = ex + 4;
        end else begin
            if (ex <= 4) begin ex = 0; eleft = 1'b0; ebounce = 1'b1; end
            else ex = ex - 4;
        end
        if (!eup) begin
            if (ey + 4 >= 704) begin ey = 704; eup = 1'b1; ebounce = 1'b1; end
            else ey = ey + 4;
        end else begin
            if (ey <= 4) begin ey = 0; eup = 1'b0; ebounce = 1'b1; end
            else ey = ey - 4;
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bounce_cnt;

        vecs[0]  = '{0, 11'd10,   10'd5,   1'b1, 24'hFF0000};
        vecs[1]  = '{0, 11'd64,   10'd5,   1'b0, 24'h000000};
        vecs[2]  = '{0, 11'd0,    10'd0,   1'b1, 24'hFF0000};
        vecs[3]  = '{0, 11'd63,   10'd63,  1'b1, 24'hFF0000};
        vecs[4]  = '{0, 11'd63,   10'd64,  1'b0, 24'h000000};
        vecs[5]  = '{0, 11'd2047, 10'd5,   1'b0, 24'h000000};
        vecs[6]  = '{1, 11'd960,  10'd448, 1'b1, 24'hFF0000};
        vecs[7]  = '{1, 11'd959,  10'd448, 1'b0, 24'h000000};
        vecs[8]  = '{1, 11'd1023, 10'd511, 1'b1, 24'hFF0000};
        vecs[9]  = '{1, 11'd1024, 10'd448, 1'b0, 24'h000000};
        vecs[10] = '{1, 11'd1000, 10'd447, 1'b0, 24'h000000};
        vecs[11] = '{1, 11'd1000, 10'd512, 1'b0, 24'h000000};

        reset_n = 1'b1; vsync = 1'b1; enable = 1'b0; hcount = '0; vcount = '0;
        reset_n_s = 1'b1; vsync_s = 1'b1; enable_s = 1'b1; hcount_s = '0; vcount_s = '0;
        #1;
        reset_n = 1'b0;
        reset_n_s = 1'b0;
        #2;
        // Asynchronous reset values before any clock edge.
        check("rst_x", 32'(x_pos), 0);
        check("rst_y", 32'(y_pos), 0);
        check("rst_hit", 32'(object_hit), 0);
        check("rst_color", 32'(object_color), 0);
        check("rst_bounce", 32'(bounce), 0);
        step(); step();
        reset_n = 1'b1;  // released with vsync high
        step(); step();
        check("no_spurious_x", 32'(x_pos), 0);

        // Hit window with sprite at origin.
        apply_group(0);

        // First tick and a held-low vsync.
        enable = 1'b1;
        vsync = 1'b0; step();
        check("tick1_x", 32'(x_pos), 4);
        check("tick1_y", 32'(y_pos), 4);
        check("tick1_bounce", 32'(bounce), 0);
        step();
        check("vsync_held_x", 32'(x_pos), 4);
        check("vsync_held_y", 32'(y_pos), 4);
        vsync = 1'b1; step();

        ex = 4; ey = 4; eleft = 1'b0; eup = 1'b0;
        for (int n = 2; n <= 240; n++) begin
            vsync = 1'b0; step();
            model_tick();
            check($sformatf("x_tick%0d", n), 32'(x_pos), 32'(ex));
            check($sformatf("y_tick%0d", n), 32'(y_pos), 32'(ey));
            check($sformatf("bounce_tick%0d", n), 32'(bounce), 32'(ebounce));
            if (n == 176) begin
                check("t176_x", 32'(x_pos), 704);
                check("t176_y", 32'(y_pos), 704);
                check("t176_bounce", 32'(bounce), 1);
            end
            if (n == 177) begin
                check("t177_x", 32'(x_pos), 708);
                check("t177_y", 32'(y_pos), 700);
            end
            if (n == 240) begin
                check("t240_x", 32'(x_pos), 960);
                check("t240_y", 32'(y_pos), 448);
                check("t240_bounce", 32'(bounce), 1);
            end
            vsync = 1'b1; step();
            check($sformatf("bounce_clear%0d", n), 32'(bounce), 0);
        end

        // Hit window with sprite against the right border.
        apply_group(1);

        // Disabled ticks leave everything alone.
        enable = 1'b0;
        for (int p = 0; p < 10; p++) begin
            vsync = 1'b0; step();
            check($sformatf("dis_x%0d", p), 32'(x_pos), 960);
            check($sformatf("dis_y%0d", p), 32'(y_pos), 448);
            check($sformatf("dis_bounce%0d", p), 32'(bounce), 0);
            vsync = 1'b1; step();
        end
        // Enable between ticks has no effect.
        enable = 1'b1;
        for (int c = 0; c < 5; c++) step();
        check("between_x", 32'(x_pos), 960);
        check("between_y", 32'(y_pos), 448);

        // Direction LEFT_UP survived the disabled ticks.
        vsync = 1'b0; step();
        check("after_dis_x", 32'(x_pos), 956);
        check("after_dis_y", 32'(y_pos), 444);
        check("after_dis_bounce", 32'(bounce), 0);
        vsync = 1'b1; step();

        // Mid-line reset with the sprite away from the origin.
        hcount = 11'd966; vcount = 10'd454;
        step();
        check("pre_rst_hit", 32'(object_hit), 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_x", 32'(x_pos), 0);
        check("mid_rst_y", 32'(y_pos), 0);
        check("mid_rst_hit", 32'(object_hit), 0);
        check("mid_rst_color", 32'(object_color), 0);
        check("mid_rst_bounce", 32'(bounce), 0);
        step(); step();
        vsync = 1'b1;
        reset_n = 1'b1;
        step();
        vsync = 1'b0; step();
        check("post_rst_x", 32'(x_pos), 4);
        check("post_rst_y", 32'(y_pos), 4);
        vsync = 1'b1; step();
        vsync = 1'b0; step();
        check("post_rst2_x", 32'(x_pos), 8);
        check("post_rst2_y", 32'(y_pos), 8);
        vsync = 1'b1; step();

        // Small instance: both axes reflect on the same tick.
        reset_n_s = 1'b1;
        step();
        bounce_cnt = 0;
        for (int n = 1; n <= 25; n++) begin
            vsync_s = 1'b0; step();
            if (bounce_s) bounce_cnt++;
            if (n == 24) begin
                check("s24_x", 32'(x_pos_s), 96);
                check("s24_y", 32'(y_pos_s), 96);
                check("s24_bounce", 32'(bounce_s), 1);
            end
            if (n == 25) begin
                check("s25_x", 32'(x_pos_s), 92);
                check("s25_y", 32'(y_pos_s), 92);
            end
            vsync_s = 1'b1; step();
            if (bounce_s) bounce_cnt++;
        end
        check("s_bounce_count", 32'(bounce_cnt), 1);

        // Small instance coverage at (92,92): right/bottom edge of active area.
        hcount_s = 11'd123; vcount_s = 10'd123; step();
        check("s_hit_in", 32'(object_hit_s), 1);
        check("s_color_in", 32'(object_color_s), 32'h00FF0000);
        hcount_s = 11'd124; vcount_s = 10'd100; step();
        check("s_hit_right", 32'(object_hit_s), 0);
        hcount_s = 11'd100; vcount_s = 10'd128; step();
        check("s_hit_vres", 32'(object_hit_s), 0);
        check("s_color_out", 32'(object_color_s), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
